tube_display: RTL and testbench

Four-digit seven-segment display driver that consumes the 14-bit binary value produced by the measurement/speed logic and drives the board's multiplexed common-cathode tubes. It converts binary to BCD with a sequential shift-add-3 engine, applies leading-zero blanking, and time-multiplexes the four digits at a fixed scan rate. It sits between `tube_data` and the top-level `seg`/`sel` pins.

---
 rtl/tube_display.sv | 209 ++++++++++++++++++++
 tb/tb_tube_display.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tube_display.sv
`default_nettype none
// ============================================================================
// Module      : tube_display
// Description : Four-digit multiplexed seven-segment driver. A sequential
//               shift-add-3 engine converts a 14-bit binary value (clamped to
//               9999) to BCD. The BCD digits are then scanned across four
//               common-cathode tubes, with optional leading-zero blanking.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SCAN_DIV  clock cycles per digit slot (2 .. 2^20)
//   BLANK_LZ  1 = blank leading zeros on digits 3..1, 0 = show every digit
// Ports
//   clk       in   1   system clock
//   rst       in   1   asynchronous active-high reset
//   data_in   in  14   binary value to display
//   seg       out  8   segment drive {dp,g,f,e,d,c,b,a}, active high
//   sel       out  4   one-hot digit enable, sel[0] = ones digit
//   bcd       out 16   converted digits {thousands,hundreds,tens,ones}
//   busy      out  1   conversion in progress
// ============================================================================
module tube_display #(
  parameter int SCAN_DIV = 100_000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] data_in,
  output logic [7:0]  seg,
  output logic [3:0]  sel,
  output logic [15:0] bcd,
  output logic        busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int          SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [13:0] MAX_VAL   = 14'd9999;
  localparam logic [3:0]  LAST_SHIFT = 4'd13;   // 14 shifts: cnt 0..13

  // --------------------------------------------------------------------------
  // Conversion FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [13:0] last, last_nxt;
  logic [13:0] bin, bin_nxt;
  logic [15:0] acc, acc_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] bcd_nxt;
  logic        busy_nxt;

  logic [13:0] data_clamped;
  logic [15:0] acc_adj;

  // Add 3 to a BCD nibble that is 5 or more, so that the following
  // doubling carries correctly into the next decimal digit.
  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  assign data_clamped = (data_in > MAX_VAL) ? MAX_VAL : data_in;
  assign acc_adj      = {add3(acc[15:12]), add3(acc[11:8]),
                         add3(acc[7:4]),   add3(acc[3:0])};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      last  <= '0;
      bin   <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      bin   <= bin_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      bcd   <= bcd_nxt;
      busy  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    bin_nxt   = bin;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    bcd_nxt   = bcd;
    busy_nxt  = busy;

    case (state)
      S_IDLE: begin
        // Input changes seen while busy are picked up here on return,
        // so the most recent value is always converted eventually.
        if (data_in != last) begin
          last_nxt  = data_in;
          bin_nxt   = data_clamped;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // {acc,bin} << 1 after the add-3 correction
        acc_nxt = {acc_adj[14:0], bin[13]};
        bin_nxt = {bin[12:0], 1'b0};
        cnt_nxt = cnt + 4'd1;
        if (cnt == LAST_SHIFT) begin
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        bcd_nxt   = acc;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Digit scan
  // --------------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        idx;
  logic [1:0]        idx_nxt;
  logic              scan_tc;
  logic [3:0]        digit_nxt;
  logic              blank_nxt;
  logic [7:0]        seg_nxt;

  function automatic logic [7:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 8'h3F;
      4'd1:    encode = 8'h06;
      4'd2:    encode = 8'h5B;
      4'd3:    encode = 8'h4F;
      4'd4:    encode = 8'h66;
      4'd5:    encode = 8'h6D;
      4'd6:    encode = 8'h7D;
      4'd7:    encode = 8'h07;
      4'd8:    encode = 8'h7F;
      4'd9:    encode = 8'h6F;
      default: encode = 8'h00;
    endcase
  endfunction

  assign scan_tc = (scan_cnt == SCAN_LAST);
  assign idx_nxt = idx + 2'd1;

  // The slot being entered is encoded from the bcd register as it stands
  // now; a conversion finishing on this same edge shows up one slot later.
  always_comb begin
    digit_nxt = 4'd0;
    blank_nxt = 1'b0;
    case (idx_nxt)
      2'd0: digit_nxt = bcd[3:0];
      2'd1: digit_nxt = bcd[7:4];
      2'd2: digit_nxt = bcd[11:8];
      2'd3: digit_nxt = bcd[15:12];
      default: digit_nxt = 4'd0;
    endcase
    if (BLANK_LZ) begin
      case (idx_nxt)
        2'd1: blank_nxt = (bcd[15:4]  == 12'd0);
        2'd2: blank_nxt = (bcd[15:8]  == 8'd0);
        2'd3: blank_nxt = (bcd[15:12] == 4'd0);
        default: blank_nxt = 1'b0;
      endcase
    end
    seg_nxt = blank_nxt ? 8'h00 : encode(digit_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      sel      <= 4'b0001;
      seg      <= 8'h3F;
    end else if (scan_tc) begin
      scan_cnt <= '0;
      idx      <= idx_nxt;
      sel      <= 4'b0001 << idx_nxt;
      seg      <= seg_nxt;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tube_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_tube_display
// Description : Self-checking bench for tube_display. Two instances share the
//               stimulus: one with leading-zero blanking, one without.
//               Expected BCD values are queued when data_in is driven and
//               popped when a conversion completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tube_display;

  localparam int SD = 4;

  logic        clk;
  logic        rst;
  logic [13:0] data_in;
  logic [7:0]  seg,  seg_nb;
  logic [3:0]  sel,  sel_nb;
  logic [15:0] bcd,  bcd_nb;
  logic        busy, busy_nb;

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb[$];

  tube_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in),
    .seg(seg), .sel(sel), .bcd(bcd), .busy(busy)
  );

  tube_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .data_in(data_in),
    .seg(seg_nb), .sel(sel_nb), .bcd(bcd_nb), .busy(busy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic logic [7:0] seg_exp(input logic [15:0] b, input int idx, input bit blank);
    logic [3:0]  d;
    logic [15:0] hi;
    d  = b[idx*4 +: 4];
    hi = b >> (idx * 4);
    if (blank && idx != 0 && hi == 16'd0) return 8'h00;
    case (d)
      4'd0: return 8'h3F;  4'd1: return 8'h06;  4'd2: return 8'h5B;
      4'd3: return 8'h4F;  4'd4: return 8'h66;  4'd5: return 8'h6D;
      4'd6: return 8'h7D;  4'd7: return 8'h07;  4'd8: return 8'h7F;
      4'd9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // Waits for a conversion to run to completion, measures its busy length
  // and the delay until busy rose, then compares bcd against the scoreboard.
  task automatic conv(input string tag, input int exp_len, input int exp_wait);
    int w = 0;
    int n = 0;
    logic [15:0] e;
    while (!busy && w < 8) begin @(negedge clk); w++; end
    while (busy && n < 40) begin @(negedge clk); n++; end
    if (exp_wait >= 0) check({tag, " busy_start"}, w, exp_wait);
    if (exp_len  >= 0) check({tag, " busy_len"},   n, exp_len);
    if (sb.size() > 0) e = sb.pop_front();
    else               e = 'x;
    check({tag, " bcd"},    bcd,    e);
    check({tag, " bcd_nb"}, bcd_nb, e);
  endtask

  // Syncs to a slot boundary, then checks four consecutive slots.
  task automatic refresh(input string tag, input logic [15:0] exp_bcd);
    int idx = 0;
    int n;
    logic [3:0] prev;
    prev = sel;
    n = 0;
    while (sel == prev && n < 3*SD) begin @(negedge clk); n++; end
    for (int k = 0; k < 4; k++) if (sel[k]) idx = k;
    for (int s = 0; s < 4; s++) begin
      prev = sel;
      n = 0;
      do begin @(negedge clk); n++; end while (sel == prev && n < 3*SD);
      idx = (idx + 1) % 4;
      check({tag, " period"}, n, SD);
      check({tag, " sel"},    sel,    32'(1) << idx);
      check({tag, " sel_nb"}, sel_nb, 32'(1) << idx);
      check({tag, " seg"},    seg,    seg_exp(exp_bcd, idx, 1'b1));
      check({tag, " seg_nb"}, seg_nb, seg_exp(exp_bcd, idx, 1'b0));
    end
  endtask

  initial begin
    int hi_cnt;
    rst     = 1'b1;
    data_in = 14'd0;
    #1;
    check("t0 async sel",  sel,  4'b0001);
    check("t0 async seg",  seg,  8'h3F);
    repeat (3) @(negedge clk);
    check("t0 rst sel",  sel,  4'b0001);
    check("t0 rst seg",  seg,  8'h3F);
    check("t0 rst bcd",  bcd,  16'h0000);
    check("t0 rst busy", busy, 1'b0);

    // 1: idle scan of zero
    rst = 1'b0;
    refresh("t1", 16'h0000);
    check("t1 busy", busy, 1'b0);
    check("t1 bcd",  bcd,  16'h0000);

    // 2: 1234
    @(negedge clk);
    data_in = 14'd1234; sb.push_back(to_bcd(1234));
    conv("t2", 15, 1);
    refresh("t2", 16'h1234);

    // 3: clamp
    data_in = 14'd12000; sb.push_back(to_bcd(12000));
    conv("t3", 15, 1);
    refresh("t3", 16'h9999);

    // 4: blanking vs no blanking, interior zeros
    data_in = 14'd7; sb.push_back(to_bcd(7));
    conv("t4a", 15, 1);
    refresh("t4a", 16'h0007);
    data_in = 14'd1005; sb.push_back(to_bcd(1005));
    conv("t4b", 15, 1);
    refresh("t4b", 16'h1005);

    // 5: changes while busy; only the first and last value convert
    data_in = 14'd100; sb.push_back(to_bcd(100));
    @(negedge clk);
    data_in = 14'd200;
    @(negedge clk);
    data_in = 14'd300; sb.push_back(to_bcd(300));
    conv("t5a", -1, -1);
    conv("t5b", 15, 1);
    hi_cnt = 0;
    repeat (20) begin @(negedge clk); if (busy) hi_cnt++; end
    check("t5 no_third", hi_cnt, 0);
    check("t5 sb_empty", sb.size(), 0);

    // 6: reset mid-conversion
    data_in = 14'd4321; sb.push_back(to_bcd(4321));
    @(negedge clk);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6 rst seg",  seg,  8'h3F);
    check("t6 rst sel",  sel,  4'b0001);
    check("t6 rst bcd",  bcd,  16'h0000);
    check("t6 rst busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    conv("t6", 15, 1);
    refresh("t6", 16'h4321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
